// File: rtl/game_menu_ctrl.sv
// game_menu_ctrl: menu / launch / play / exit sequencer for the game console datapath.
// Define SPEED_ADJ_EN to let the left button step the pong speed while in the menu.
module game_menu_ctrl #(
  parameter int RST_CYCLES    = 1024,
  parameter int SPEED_DEFAULT = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       button_up,
  input  logic       button_down,
  input  logic       button_left,
  input  logic       button_right,
  input  logic       exit,
  output logic [1:0] vgaMUX,
  output logic [2:0] choice,
  output logic       gamein_rst,
  output logic [3:0] speedcontrol,
  output logic       playing
);

  localparam int               CNT_W     = $clog2(RST_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(RST_CYCLES - 1);
  localparam logic [3:0]       SPEED_RST = 4'(SPEED_DEFAULT);

  typedef enum logic [1:0] {
    MENU   = 2'd0,
    LAUNCH = 2'd1,
    PLAY   = 2'd2,
    EXIT   = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             up_prev_r, down_prev_r, left_prev_r, right_prev_r, exit_prev_r;
  logic             up_evt_s, down_evt_s, left_evt_s, right_evt_s, exit_evt_s;

  assign up_evt_s    = button_up    & ~up_prev_r;
  assign down_evt_s  = button_down  & ~down_prev_r;
  assign left_evt_s  = button_left  & ~left_prev_r;
  assign right_evt_s = button_right & ~right_prev_r;
  assign exit_evt_s  = exit         & ~exit_prev_r;

  // Previous-level history for rising-edge detection on all five inputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      up_prev_r    <= 1'b0;
      down_prev_r  <= 1'b0;
      left_prev_r  <= 1'b0;
      right_prev_r <= 1'b0;
      exit_prev_r  <= 1'b0;
    end else begin
      up_prev_r    <= button_up;
      down_prev_r  <= button_down;
      left_prev_r  <= button_left;
      right_prev_r <= button_right;
      exit_prev_r  <= exit;
    end
  end

  // Main sequencer: state, cursor, reset-pulse counter and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r    <= MENU;
      choice     <= 3'd0;
      vgaMUX     <= 2'd0;
      gamein_rst <= 1'b1;
      playing    <= 1'b0;
      cnt_r      <= CNT_W'(0);
    end else if (choice > 3'd2) begin
      state_r    <= MENU;
      choice     <= 3'd0;
      vgaMUX     <= 2'd0;
      gamein_rst <= 1'b1;
      playing    <= 1'b0;
    end else begin
      case (state_r)
        MENU: begin
          vgaMUX     <= 2'd0;
          gamein_rst <= 1'b1;
          playing    <= 1'b0;
          if (right_evt_s) begin
            // Launch wins over cursor moves; the game under the cursor starts.
            cnt_r   <= CNT_LOAD;
            state_r <= LAUNCH;
            vgaMUX  <= choice[1:0] + 2'd1;
          end else if (up_evt_s && !down_evt_s) begin
            choice <= (choice == 3'd0) ? 3'd2 : choice - 3'd1;
          end else if (down_evt_s && !up_evt_s) begin
            choice <= (choice == 3'd2) ? 3'd0 : choice + 3'd1;
          end else begin
            choice <= choice;
          end
        end
        LAUNCH: begin
          vgaMUX     <= choice[1:0] + 2'd1;
          gamein_rst <= 1'b1;
          playing    <= 1'b0;
          if (exit_evt_s) begin
            cnt_r   <= CNT_LOAD;
            state_r <= EXIT;
            vgaMUX  <= 2'd0;
          end else if (cnt_r == CNT_W'(0)) begin
            state_r    <= PLAY;
            gamein_rst <= 1'b0;
            playing    <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        PLAY: begin
          vgaMUX     <= choice[1:0] + 2'd1;
          gamein_rst <= 1'b0;
          playing    <= 1'b1;
          if (exit_evt_s) begin
            cnt_r      <= CNT_LOAD;
            state_r    <= EXIT;
            vgaMUX     <= 2'd0;
            gamein_rst <= 1'b1;
            playing    <= 1'b0;
          end else begin
            state_r <= PLAY;
          end
        end
        EXIT: begin
          vgaMUX     <= 2'd0;
          gamein_rst <= 1'b1;
          playing    <= 1'b0;
          if (cnt_r == CNT_W'(0)) begin
            state_r <= MENU;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r    <= MENU;
          choice     <= 3'd0;
          vgaMUX     <= 2'd0;
          gamein_rst <= 1'b1;
          playing    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPEED_ADJ_EN
  // Pong speed: stepped 1..15 with wrap by left events in the menu, frozen elsewhere.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      speedcontrol <= SPEED_RST;
    end else if (state_r == MENU && choice <= 3'd2 && left_evt_s && !right_evt_s) begin
      speedcontrol <= (speedcontrol == 4'd15) ? 4'd1 : speedcontrol + 4'd1;
    end else begin
      speedcontrol <= speedcontrol;
    end
  end
`else
  logic unused_left_s;
  assign unused_left_s = left_evt_s;

  // Pong speed is fixed at its default when adjustment is not built in.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      speedcontrol <= SPEED_RST;
    end else begin
      speedcontrol <= SPEED_RST;
    end
  end
`endif

endmodule

// File: tb/tb_game_menu_ctrl.sv
// Self-checking bench for game_menu_ctrl: directed plan steps, then random buttons vs a reference model.
module tb_game_menu_ctrl;

  localparam int RST_CYCLES    = 4;
  localparam int SPEED_DEFAULT = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst, button_up, button_down, button_left, button_right, exit;
  logic [1:0] vgaMUX;
  logic [2:0] choice;
  logic       gamein_rst, playing;
  logic [3:0] speedcontrol;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: phase 0 menu, 1 launching, 2 playing, 3 exiting; hold = reset cycles left.
  int m_phase, m_cursor, m_hold, m_speed;
  bit p_up, p_dn, p_lf, p_rt, p_ex;

  game_menu_ctrl #(.RST_CYCLES(RST_CYCLES), .SPEED_DEFAULT(SPEED_DEFAULT)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .button_up(button_up), .button_down(button_down),
    .button_left(button_left), .button_right(button_right), .exit(exit),
    .vgaMUX(vgaMUX), .choice(choice), .gamein_rst(gamein_rst),
    .speedcontrol(speedcontrol), .playing(playing)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic void model_step();
    bit eu, ed, el, er, ee;
    if (sys_rst) begin
      m_phase = 0; m_cursor = 0; m_hold = 0; m_speed = SPEED_DEFAULT;
      p_up = 0; p_dn = 0; p_lf = 0; p_rt = 0; p_ex = 0;
      return;
    end
    eu = button_up && !p_up;   ed = button_down && !p_dn; el = button_left && !p_lf;
    er = button_right && !p_rt; ee = exit && !p_ex;
    p_up = button_up; p_dn = button_down; p_lf = button_left; p_rt = button_right; p_ex = exit;
    case (m_phase)
      0: begin
        if (er) begin
          m_phase = 1; m_hold = RST_CYCLES;
        end else begin
          if (eu && !ed) m_cursor = (m_cursor + 2) % 3;
          if (ed && !eu) m_cursor = (m_cursor + 1) % 3;
`ifdef SPEED_ADJ_EN
          if (el) m_speed = (m_speed % 15) + 1;
`endif
        end
      end
      1: begin
        if (ee) begin
          m_phase = 3; m_hold = RST_CYCLES;
        end else begin
          m_hold--;
          if (m_hold == 0) m_phase = 2;
        end
      end
      2: if (ee) begin m_phase = 3; m_hold = RST_CYCLES; end
      default: begin
        m_hold--;
        if (m_hold == 0) m_phase = 0;
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int exp_vga;
    exp_vga = (m_phase == 1 || m_phase == 2) ? m_cursor + 1 : 0;
    chk({tag, ":vgaMUX"}, 32'(vgaMUX), exp_vga);
    chk({tag, ":choice"}, 32'(choice), m_cursor);
    chk({tag, ":gamein_rst"}, 32'(gamein_rst), (m_phase == 2) ? 0 : 1);
    chk({tag, ":playing"}, 32'(playing), (m_phase == 2) ? 1 : 0);
    chk({tag, ":speed"}, 32'(speedcontrol), m_speed);
  endtask

  task automatic cycle(input string tag);
    @(posedge sys_clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic drive(input bit u, input bit d, input bit l, input bit r, input bit e);
    button_up = u; button_down = d; button_left = l; button_right = r; exit = e;
  endtask

  initial begin
    sys_rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    // Reset state
    cycle("reset"); cycle("reset");
    chk("rst_vga", 32'(vgaMUX), 0);
    chk("rst_choice", 32'(choice), 0);
    chk("rst_gamein", 32'(gamein_rst), 1);
    chk("rst_speed", 32'(speedcontrol), 4);
    chk("rst_playing", 32'(playing), 0);
    sys_rst = 1'b0;
    cycle("idle");

    // Cursor wrap-around
    drive(1, 0, 0, 0, 0); cycle("up_wrap");
    chk("up_wrap_choice", 32'(choice), 2);
    drive(0, 0, 0, 0, 0); cycle("rel");
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0, 0); cycle("down");
      drive(0, 0, 0, 0, 0); cycle("rel");
    end
    chk("down2_choice", 32'(choice), 1);
    drive(1, 0, 0, 0, 0); cycle("up_held");
    cycle("up_held");
    chk("up_held_once", 32'(choice), 0);
    drive(0, 0, 0, 0, 0); cycle("rel");

    // Speed stepping (or lack of it)
`ifdef SPEED_ADJ_EN
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 1, 0, 0); cycle("left");
      drive(0, 0, 0, 0, 0); cycle("rel");
    end
    chk("speed_wrap", 32'(speedcontrol), 1);
`else
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0); cycle("left");
      drive(0, 0, 0, 0, 0); cycle("rel");
    end
    chk("speed_const", 32'(speedcontrol), 4);
`endif

    // Launch game 2 (tetris)
    drive(0, 1, 0, 0, 0); cycle("down");
    drive(0, 1, 0, 0, 0); cycle("down_held");
    drive(0, 0, 0, 0, 0); cycle("rel");
    drive(0, 1, 0, 0, 0); cycle("down");
    drive(0, 0, 0, 0, 0); cycle("rel");
    chk("pre_launch_choice", 32'(choice), 2);
    drive(0, 0, 0, 1, 0); cycle("launch");
    chk("launch_vga", 32'(vgaMUX), 3);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle("launching");
      chk("launch_rst_hi", 32'(gamein_rst), 1);
    end
    cycle("launch_done");
    chk("launch_rst_lo", 32'(gamein_rst), 0);
    chk("launch_playing", 32'(playing), 1);
    drive(1, 1, 1, 1, 0); cycle("play_buttons");
    drive(0, 0, 0, 0, 0); cycle("rel");
    chk("play_speed_frozen", 32'(speedcontrol), m_speed);

    // Exit back to menu
    drive(0, 0, 0, 0, 1); cycle("exit");
    chk("exit_vga", 32'(vgaMUX), 0);
    chk("exit_rst", 32'(gamein_rst), 1);
    drive(0, 0, 0, 0, 0);
    cycle("exiting"); cycle("exiting"); cycle("exiting");
    drive(1, 0, 0, 0, 0); cycle("exit_last");
    chk("exit_last_ignored", 32'(choice), 2);
    drive(0, 0, 0, 0, 0); cycle("rel");
    drive(1, 0, 0, 0, 0); cycle("menu_up");
    chk("menu_after_exit", 32'(choice), 1);
    drive(0, 0, 0, 0, 0); cycle("rel");

    // Simultaneous inputs
    drive(1, 1, 0, 0, 0); cycle("updown");
    chk("updown_nomove", 32'(choice), 1);
    drive(0, 0, 0, 0, 0); cycle("rel");
    drive(1, 0, 0, 1, 0); cycle("up_right");
    chk("up_right_vga", 32'(vgaMUX), 2);
    chk("up_right_choice", 32'(choice), 1);
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle("held_launch");
    drive(0, 0, 0, 1, 1); cycle("held_exit");
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) cycle("held_menu");
    chk("held_no_relaunch", 32'(vgaMUX), 0);
    drive(0, 0, 0, 0, 0); cycle("rel");
    drive(0, 0, 0, 1, 0); cycle("relaunch");
    chk("relaunch_vga", 32'(vgaMUX), 2);

    // Reset mid-launch at count 2
    drive(0, 0, 0, 0, 0); cycle("launching");
    sys_rst = 1'b1; cycle("mid_reset");
    chk("mid_rst_vga", 32'(vgaMUX), 0);
    chk("mid_rst_choice", 32'(choice), 0);
    chk("mid_rst_gamein", 32'(gamein_rst), 1);
    sys_rst = 1'b0; cycle("idle");

    // Randomized buttons against the model
    for (int i = 0; i < 1500; i++) begin
      sys_rst = ($urandom_range(0, 299) == 0);
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
      cycle("random");
    end
    sys_rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/game_menu_ctrl.md
# game_menu_ctrl

Top-level sequencer for the game console datapath. Runs the menu (cursor over three games), launches the selected game with a timed reset pulse, routes the VGA/seven-segment mux to that game, and returns to the menu on the exit request. It drives the datapath's `vgaMUX`, `choice`, `gamein_rst` and `speedcontrol` inputs, and consumes the datapath's debounced `button_*` and `exit` feedback.

## Interface
- `RST_CYCLES`, 1024: number of cycles `game_rst` is held on launch and on exit; legal range 2..65535.
- `SPEED_DEFAULT`, 4: reset value of `speedcontrol`; legal range 1..15.
- `sys_clk` in 1: system clock; every register is on its rising edge.
- `sys_rst` in 1: synchronous, active-high reset.
- `button_up` in 1: debounced level, cursor up.
- `button_down` in 1: debounced level, cursor down.
- `button_left` in 1: debounced level; speed step when `SPEED_ADJ_EN` is defined.
- `button_right` in 1: debounced level, launch the game under the cursor.
- `exit` in 1: level, exit request from a running game.
- `vgaMUX` out 2: display/segment source. 0 = menu background, 1 = snake, 2 = pong, 3 = tetris.
- `choice` out 3: cursor position, binary 0..2, for highlighting in the background renderer.
- `gamein_rst` out 1: active-high reset to all game cores.
- `speedcontrol` out 4: pong bar speed, range 1..15.
- `playing` out 1: high only in the PLAY state.

## Operation
- **Edge detection.** Each of the five inputs has a `prev` register. The event is `in & ~prev`. A level held across a state change never produces a second event.
- **State machine:** MENU, LAUNCH, PLAY, EXIT. Every output is registered.
- **MENU**
  - `vgaMUX`=0, `gamein_rst`=1.
  - Up event: `choice` = `choice`==0 ? 2 : `choice`-1.
  - Down event: `choice` = `choice`==2 ? 0 : `choice`+1.
  - Up and down in the same cycle: no move.
  - Right event: load the counter with RST_CYCLES-1 and go to LAUNCH. Right has priority over up/down in the same cycle; the cursor does not move.
  - Exit is ignored.
- **LAUNCH**
  - `vgaMUX` = `choice`+1, `gamein_rst`=1.
  - Counter decrements each cycle. At 0, go to PLAY.
  - An exit event reloads the counter and goes to EXIT.
- **PLAY**
  - `vgaMUX` = `choice`+1, `gamein_rst`=0, `playing`=1.
  - Buttons are ignored by this block; the games consume them.
  - An exit event reloads the counter and goes to EXIT.
- **EXIT**
  - `vgaMUX`=0, `gamein_rst`=1.
  - Counter decrements each cycle. At 0, go to MENU.
  - `choice` is preserved, so the cursor returns to the last game played.
- **Illegal values** of state or `choice` recover to MENU / 0 on the next edge.
- **Counter** width is clog2(RST_CYCLES). It is held when not in LAUNCH or EXIT.

## Timing
- **Reset values** (`sys_rst` high at an edge):
  - state MENU, `choice`=0, `vgaMUX`=0, `gamein_rst`=1
  - `speedcontrol`=SPEED_DEFAULT, `playing`=0, all `prev` registers 0
- Reset in any state aborts that state at the same edge.
- An input first sampled high at edge n updates outputs at edge n (one registered stage; no extra latency).
- **Launch timing:** `gamein_rst` stays high for exactly RST_CYCLES cycles after the launch edge, then drops together with `playing` rising.
- **Exit timing:** `vgaMUX` goes to 0 on the same edge the exit event is taken. `gamein_rst` is high for RST_CYCLES cycles, then the block is in MENU.
- `vgaMUX` never takes a game value while in MENU or EXIT.

## Configuration
- **`SPEED_ADJ_EN` defined:**
  - In MENU, a left event steps `speedcontrol` by +1, wrapping 15→1; 0 is never produced.
  - If left and right occur in the same cycle, right wins.
  - `speedcontrol` is frozen outside MENU.
- **`SPEED_ADJ_EN` undefined:**
  - `button_left` is unused.
  - `speedcontrol` is constant SPEED_DEFAULT.

## Test plan
- **Reset and wrap-around** (RST_CYCLES=4): assert reset → `vgaMUX`=0, `choice`=0, `gamein_rst`=1, `speedcontrol`=4. Then up pulse → `choice`=2; down ×2 → `choice`=1.
- **Launch:** `choice`=2, right pulse → `vgaMUX`=3 on that edge; `gamein_rst`=1 for 4 cycles, then 0 with `playing`=1.
- **Exit:** in PLAY, exit pulse → `vgaMUX`=0 on that edge; `gamein_rst`=1 for 4 cycles; back in MENU with `choice`=2.
- **Simultaneous and held inputs:**
  - up+down together → `choice` unchanged.
  - up+right together → launch with the unmoved cursor.
  - right held through launch and exit → no relaunch until it is released and pressed again.
- **`SPEED_ADJ_EN` defined:** 12 left pulses from 4 → `speedcontrol`=1. Left pulse during PLAY → unchanged.
- **Reset mid-operation:** `sys_rst` during LAUNCH at count 2 → next edge MENU, `vgaMUX`=0, `choice`=0, `gamein_rst`=1.
